pcr_redirect_arb: RTL and testbench
===================================

# pcr_redirect_arb

Next-PC request arbiter and sequencer sitting in front of the PC register's receive port. It collects next-PC requests from the EXU, the LSU and the CSR trap unit, selects one by priority, and holds it on the PC register's valid/ready port until accepted. It also handles trap preemption, debug halt, misaligned-target detection and a grant counter.

## Interface
- RR_EN, 1, 1 = round-robin between EXU and LSU; 0 = EXU fixed priority over LSU
- CNT_W, 32, width of grant_cnt
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- trap_valid  in  1  one-cycle trap/redirect pulse from CSR unit (no ready)
- trap_pc  in  32  trap target PC
- exu_valid  in  1  EXU next-PC request
- exu_ready  out  1  EXU request accepted (combinational)
- exu_bc_valid  in  1  EXU request is a taken branch/jump
- exu_bc_pc  in  32  EXU branch target
- lsu_valid  in  1  LSU next-PC request
- lsu_ready  out  1  LSU request accepted (combinational)
- lsu_bc_valid  in  1  LSU request carries a redirect
- lsu_bc_pc  in  32  LSU redirect target
- halt  in  1  debug halt; blocks new grants
- pcr_rx_valid  out  1  request to PC register
- pcr_rx_ready  in  1  PC register accepts
- pcr_rx_bc_valid  out  1  redirect flag to PC register (0 = sequential PC+4)
- pcr_rx_bc_pc  out  32  redirect target to PC register
- busy  out  1  state is S_HOLD or trap_pend set
- misalign_err  out  1  one-cycle pulse: captured redirect target had pc[1:0] != 0
- grant_cnt  out  CNT_W  count of completed pcr_rx handshakes

## Operation
- States: S_IDLE (no request held), S_HOLD (request held on pcr_rx_*).
- Trap capture: on trap_valid, trap_pend <= 1 and trap_pend_pc <= trap_pc. A new trap overwrites any pending trap (latest wins).
- Trap request is active when trap_valid || trap_pend. Its PC is trap_pc if trap_valid, else trap_pend_pc.
- S_IDLE with halt = 0, grant order:
  - Active trap first: capture it with bc_valid = 1, clear trap_pend, go to S_HOLD.
  - Otherwise EXU/LSU: with RR_EN = 1 and both valid, grant the source not granted last; with a single valid source, grant it; with RR_EN = 0, EXU wins.
  - The granted source's ready = 1 in the same cycle. Capture its bc_valid/bc_pc, go to S_HOLD, update the RR pointer (EXU/LSU grants only).
- exu_ready/lsu_ready are 0 in S_HOLD, during halt, while a trap request is active, and during reset.
- S_HOLD: pcr_rx_valid = 1 with stable payload. On pcr_rx_ready: go to S_IDLE, grant_cnt += 1, wrapping to 0.
- Trap preemption in S_HOLD with no handshake this cycle:
  - Held non-trap payload: replaced next cycle by the trap PC with bc_valid = 1. The held request is squashed, not retried, and trap_pend is cleared. This is the only permitted payload change while valid.
  - Held trap payload: the new trap goes to trap_pend.
- Trap in the same cycle as a handshake: the held request completes and the trap goes to trap_pend, issued from S_IDLE next cycle.
- halt: gates new grants in S_IDLE, including traps. Traps are still latched. A request already in S_HOLD still completes.
- Misalign: applies to any capture with bc_valid = 1 (including trap or preemption).
  - If pc[1:0] != 0: stored pcr_rx_bc_pc has [1:0] forced to 2'b00, and misalign_err pulses for one cycle, coincident with the first pcr_rx_valid cycle of that payload.
  - bc_valid = 0 captures never flag.
- When bc_valid = 0, pcr_rx_bc_pc holds the last value; it is a don't-care for consumers.
- Reset values:
  - state S_IDLE; trap_pend 0; RR pointer = LSU (EXU wins first tie).
  - pcr_rx_valid 0; pcr_rx_bc_valid 0; pcr_rx_bc_pc 0.
  - exu_ready 0; lsu_ready 0; busy 0; misalign_err 0; grant_cnt 0.
- Reset asserted mid-operation: the held request and pending trap are discarded immediately.

## Timing
- Requester handshake at cycle N → pcr_rx_valid = 1 at N+1.
- Trap pulse at N in S_IDLE → pcr_rx_valid at N+1.
- Preemption: trap at N in S_HOLD → trap payload visible at N+1.
- Handshake at N → S_IDLE at N+1 → earliest next grant at N+1 → next pcr_rx_valid at N+2. Maximum throughput is one request per 2 cycles.
- grant_cnt updates at N+1 after a handshake at N.

## Test plan
- EXU only, exu_bc_valid = 0, pcr_rx_ready = 1 → exu_ready at cycle 0; pcr_rx_valid at 1 with bc_valid = 0; grant_cnt = 1 at 2.
- EXU and LSU both valid for 4 grants, RR_EN = 1 → grant order EXU, LSU, EXU, LSU; with RR_EN = 0 → EXU ×4 while LSU is starved.
- EXU branch to 0x0000_1000 held with pcr_rx_ready = 0; trap_pc = 0x8000_0100 pulsed → next cycle payload is 0x8000_0100 with bc_valid = 1; after ready, only one handshake, and the EXU branch is never issued.
- Trap pulse in the same cycle as a handshake → handshake completes, busy stays 1, trap issued with pcr_rx_valid 2 cycles after the pulse.
- halt = 1 with EXU valid and a trap pulse → no ready and no pcr_rx_valid for 10 cycles, busy = 1; release halt → trap issued first, then EXU.
- LSU redirect to 0x0000_2002 → pcr_rx_bc_pc = 0x0000_2000 and one misalign_err pulse; assert rstn low while in S_HOLD → all outputs return to reset values.

Source files
------------

// File: rtl/pcr_redirect_arb.sv
// Next-PC request arbiter in front of the PC register receive port.
// Picks trap, EXU or LSU by priority and holds the winner on a valid/ready port until accepted.
module pcr_redirect_arb #(
   parameter bit RR_EN = 1'b1,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             trap_valid,
   input  logic [31:0]      trap_pc,
   input  logic             exu_valid,
   output logic             exu_ready,
   input  logic             exu_bc_valid,
   input  logic [31:0]      exu_bc_pc,
   input  logic             lsu_valid,
   output logic             lsu_ready,
   input  logic             lsu_bc_valid,
   input  logic [31:0]      lsu_bc_pc,
   input  logic             halt,
   output logic             pcr_rx_valid,
   input  logic             pcr_rx_ready,
   output logic             pcr_rx_bc_valid,
   output logic [31:0]      pcr_rx_bc_pc,
   output logic             busy,
   output logic             misalign_err,
   output logic [CNT_W-1:0] grant_cnt
);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t      state;
   logic        trap_pend;
   logic [31:0] trap_pend_pc;
   logic        held_trap;
   logic        rr_last_exu;

   logic        trap_act;
   logic [31:0] trap_pc_sel;
   logic        idle_open;
   logic        pick_lsu;
   logic        preempt;
   logic        cap_en;
   logic        cap_trap;
   logic        cap_bc;
   logic [31:0] cap_pc;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   function automatic logic is_misaligned(input logic bc, input logic [31:0] pc);
      return bc && (pc[1:0] != 2'b00);
   endfunction

   assign trap_act    = trap_valid | trap_pend;
   assign trap_pc_sel = trap_valid ? trap_pc : trap_pend_pc;
   assign idle_open   = rstn && (state == S_IDLE) && !halt;

   // Tie between EXU and LSU goes to whoever was not granted last when round-robin is on.
   always_comb begin
      pick_lsu = lsu_valid;
      if (exu_valid && lsu_valid)
         pick_lsu = RR_EN ? rr_last_exu : 1'b0;
   end

   assign exu_ready = idle_open && !trap_act && exu_valid && !pick_lsu;
   assign lsu_ready = idle_open && !trap_act && lsu_valid &&  pick_lsu;

   // A trap may only displace a held requester payload, never another trap.
   assign preempt = (state == S_HOLD) && !pcr_rx_ready && trap_valid && !held_trap;

   always_comb begin
      cap_en   = 1'b0;
      cap_trap = 1'b0;
      cap_bc   = 1'b0;
      cap_pc   = 32'd0;
      if ((idle_open && trap_act) || preempt) begin
         cap_en   = 1'b1;
         cap_trap = 1'b1;
         cap_bc   = 1'b1;
         cap_pc   = trap_pc_sel;
      end else if (exu_ready) begin
         cap_en = 1'b1;
         cap_bc = exu_bc_valid;
         cap_pc = exu_bc_pc;
      end else if (lsu_ready) begin
         cap_en = 1'b1;
         cap_bc = lsu_bc_valid;
         cap_pc = lsu_bc_pc;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= S_IDLE;
         trap_pend       <= 1'b0;
         trap_pend_pc    <= 32'd0;
         held_trap       <= 1'b0;
         rr_last_exu     <= 1'b0;
         pcr_rx_bc_valid <= 1'b0;
         pcr_rx_bc_pc    <= 32'd0;
         misalign_err    <= 1'b0;
         grant_cnt       <= '0;
      end else begin
         misalign_err <= 1'b0;
         if (trap_valid) begin
            trap_pend    <= 1'b1;
            trap_pend_pc <= trap_pc;
         end
         if (state == S_HOLD && pcr_rx_ready) begin
            state     <= S_IDLE;
            grant_cnt <= grant_cnt + CNT_W'(1);
         end
         if (cap_en) begin
            state           <= S_HOLD;
            held_trap       <= cap_trap;
            pcr_rx_bc_valid <= cap_bc;
            misalign_err    <= is_misaligned(cap_bc, cap_pc);
            if (cap_bc)
               pcr_rx_bc_pc <= align_pc(cap_pc);
            if (cap_trap)
               trap_pend <= 1'b0;
            else
               rr_last_exu <= exu_ready;
         end
      end
   end

   assign pcr_rx_valid = (state == S_HOLD);
   assign busy         = (state == S_HOLD) || trap_pend;

endmodule

// File: tb/tb_pcr_redirect_arb.sv
// Directed bench for pcr_redirect_arb: one round-robin instance, one fixed-priority instance,
// shared stimulus, hand-computed expectations.
module tb_pcr_redirect_arb;

   logic        clk;
   logic        rstn;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic        exu_valid;
   logic        exu_bc_valid;
   logic [31:0] exu_bc_pc;
   logic        lsu_valid;
   logic        lsu_bc_valid;
   logic [31:0] lsu_bc_pc;
   logic        halt;
   logic        pcr_rx_ready;

   logic        exu_ready, lsu_ready, pcr_rx_valid, pcr_rx_bc_valid, busy, misalign_err;
   logic [31:0] pcr_rx_bc_pc, grant_cnt;
   logic        exu_ready0, lsu_ready0, pcr_rx_valid0, pcr_rx_bc_valid0, busy0, misalign_err0;
   logic [31:0] pcr_rx_bc_pc0, grant_cnt0;

   int n_vec;
   int n_miss;

   pcr_redirect_arb #(.RR_EN(1'b1), .CNT_W(32)) dut (
      .clk(clk), .rstn(rstn), .trap_valid(trap_valid), .trap_pc(trap_pc),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_bc_valid(exu_bc_valid), .exu_bc_pc(exu_bc_pc),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_bc_valid(lsu_bc_valid), .lsu_bc_pc(lsu_bc_pc),
      .halt(halt), .pcr_rx_valid(pcr_rx_valid), .pcr_rx_ready(pcr_rx_ready),
      .pcr_rx_bc_valid(pcr_rx_bc_valid), .pcr_rx_bc_pc(pcr_rx_bc_pc), .busy(busy),
      .misalign_err(misalign_err), .grant_cnt(grant_cnt)
   );

   pcr_redirect_arb #(.RR_EN(1'b0), .CNT_W(32)) dut0 (
      .clk(clk), .rstn(rstn), .trap_valid(trap_valid), .trap_pc(trap_pc),
      .exu_valid(exu_valid), .exu_ready(exu_ready0), .exu_bc_valid(exu_bc_valid), .exu_bc_pc(exu_bc_pc),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready0), .lsu_bc_valid(lsu_bc_valid), .lsu_bc_pc(lsu_bc_pc),
      .halt(halt), .pcr_rx_valid(pcr_rx_valid0), .pcr_rx_ready(pcr_rx_ready),
      .pcr_rx_bc_valid(pcr_rx_bc_valid0), .pcr_rx_bc_pc(pcr_rx_bc_pc0), .busy(busy0),
      .misalign_err(misalign_err0), .grant_cnt(grant_cnt0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: act=0x%08h req=0x%08h", tag, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clr_in();
      trap_valid = 0; trap_pc = 0; exu_valid = 0; exu_bc_valid = 0; exu_bc_pc = 0;
      lsu_valid = 0; lsu_bc_valid = 0; lsu_bc_pc = 0; halt = 0; pcr_rx_ready = 0;
   endtask

   task automatic do_reset();
      rstn = 0;
      clr_in();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1;
   endtask

   logic exp_lsu;

   initial begin
      n_vec = 0;
      n_miss = 0;
      rstn = 0;
      clr_in();

      // reset values, with a requester pushing during reset
      exu_valid = 1;
      repeat (2) @(posedge clk);
      mid();
      chk("rst_exu_ready", exu_ready, 0);
      chk("rst_lsu_ready", lsu_ready, 0);
      chk("rst_valid", pcr_rx_valid, 0);
      chk("rst_bc_valid", pcr_rx_bc_valid, 0);
      chk("rst_bc_pc", pcr_rx_bc_pc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_misalign", misalign_err, 0);
      chk("rst_cnt", grant_cnt, 0);

      // EXU only, sequential next-PC
      do_reset();
      exu_valid = 1; exu_bc_valid = 0; pcr_rx_ready = 1;
      mid();
      chk("t1_exu_ready_c0", exu_ready, 1);
      chk("t1_valid_c0", pcr_rx_valid, 0);
      next_cyc();
      exu_valid = 0;
      mid();
      chk("t1_valid_c1", pcr_rx_valid, 1);
      chk("t1_bc_valid_c1", pcr_rx_bc_valid, 0);
      chk("t1_cnt_c1", grant_cnt, 0);
      next_cyc();
      mid();
      chk("t1_cnt_c2", grant_cnt, 1);
      chk("t1_valid_c2", pcr_rx_valid, 0);

      // EXU and LSU both valid: round-robin vs fixed priority
      do_reset();
      exu_valid = 1; exu_bc_valid = 1; exu_bc_pc = 32'h0000_0100;
      lsu_valid = 1; lsu_bc_valid = 1; lsu_bc_pc = 32'h0000_0200;
      pcr_rx_ready = 1;
      for (int g = 0; g < 4; g++) begin
         exp_lsu = (g % 2) == 1;
         mid();
         chk($sformatf("t2_rr_exu_ready_%0d", g), exu_ready, !exp_lsu);
         chk($sformatf("t2_rr_lsu_ready_%0d", g), lsu_ready, exp_lsu);
         chk($sformatf("t2_fp_exu_ready_%0d", g), exu_ready0, 1);
         chk($sformatf("t2_fp_lsu_ready_%0d", g), lsu_ready0, 0);
         next_cyc();
         mid();
         chk($sformatf("t2_rr_pc_%0d", g), pcr_rx_bc_pc, exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
         chk($sformatf("t2_fp_pc_%0d", g), pcr_rx_bc_pc0, 32'h0000_0100);
         chk($sformatf("t2_hold_ready_%0d", g), exu_ready | lsu_ready, 0);
         next_cyc();
      end
      mid();
      chk("t2_rr_cnt", grant_cnt, 4);
      chk("t2_fp_cnt", grant_cnt0, 4);

      // trap preempts a held EXU branch
      do_reset();
      exu_valid = 1; exu_bc_valid = 1; exu_bc_pc = 32'h0000_1000; pcr_rx_ready = 0;
      mid();
      chk("t3_exu_ready", exu_ready, 1);
      next_cyc();
      exu_valid = 0;
      mid();
      chk("t3_held_pc", pcr_rx_bc_pc, 32'h0000_1000);
      next_cyc();
      trap_valid = 1; trap_pc = 32'h8000_0100;
      mid();
      chk("t3_stable_pc", pcr_rx_bc_pc, 32'h0000_1000);
      next_cyc();
      trap_valid = 0; pcr_rx_ready = 1;
      mid();
      chk("t3_trap_pc", pcr_rx_bc_pc, 32'h8000_0100);
      chk("t3_trap_bc", pcr_rx_bc_valid, 1);
      chk("t3_trap_valid", pcr_rx_valid, 1);
      chk("t3_cnt_pre", grant_cnt, 0);
      next_cyc();
      mid();
      chk("t3_valid_after", pcr_rx_valid, 0);
      chk("t3_cnt_after", grant_cnt, 1);
      chk("t3_busy_after", busy, 0);
      repeat (3) next_cyc();
      mid();
      chk("t3_no_retry_valid", pcr_rx_valid, 0);
      chk("t3_no_retry_cnt", grant_cnt, 1);

      // trap in the same cycle as a handshake
      do_reset();
      exu_valid = 1; exu_bc_valid = 0; pcr_rx_ready = 1;
      next_cyc();
      exu_valid = 0; trap_valid = 1; trap_pc = 32'h0000_0300;
      mid();
      chk("t4_hs_valid", pcr_rx_valid, 1);
      chk("t4_hs_bc", pcr_rx_bc_valid, 0);
      next_cyc();
      trap_valid = 0;
      mid();
      chk("t4_gap_valid", pcr_rx_valid, 0);
      chk("t4_gap_busy", busy, 1);
      chk("t4_gap_cnt", grant_cnt, 1);
      next_cyc();
      mid();
      chk("t4_trap_valid", pcr_rx_valid, 1);
      chk("t4_trap_pc", pcr_rx_bc_pc, 32'h0000_0300);
      chk("t4_trap_bc", pcr_rx_bc_valid, 1);
      next_cyc();
      mid();
      chk("t4_cnt_end", grant_cnt, 2);
      chk("t4_busy_end", busy, 0);

      // halt blocks grants, trap still latched and issued first on release
      do_reset();
      halt = 1; exu_valid = 1; exu_bc_valid = 1; exu_bc_pc = 32'h0000_0500;
      trap_valid = 1; trap_pc = 32'h0000_0400; pcr_rx_ready = 1;
      for (int i = 0; i < 10; i++) begin
         mid();
         chk($sformatf("t5_halt_ready_%0d", i), exu_ready, 0);
         chk($sformatf("t5_halt_valid_%0d", i), pcr_rx_valid, 0);
         if (i > 0) chk($sformatf("t5_halt_busy_%0d", i), busy, 1);
         next_cyc();
         trap_valid = 0;
      end
      halt = 0;
      mid();
      chk("t5_rel_exu_ready", exu_ready, 0);
      next_cyc();
      mid();
      chk("t5_trap_valid", pcr_rx_valid, 1);
      chk("t5_trap_pc", pcr_rx_bc_pc, 32'h0000_0400);
      chk("t5_trap_exu_ready", exu_ready, 0);
      next_cyc();
      mid();
      chk("t5_exu_ready", exu_ready, 1);
      next_cyc();
      exu_valid = 0;
      mid();
      chk("t5_exu_pc", pcr_rx_bc_pc, 32'h0000_0500);
      chk("t5_exu_valid", pcr_rx_valid, 1);

      // misaligned LSU redirect, then async reset while holding
      do_reset();
      lsu_valid = 1; lsu_bc_valid = 1; lsu_bc_pc = 32'h0000_2002; pcr_rx_ready = 0;
      mid();
      chk("t6_lsu_ready", lsu_ready, 1);
      chk("t6_mis_c0", misalign_err, 0);
      next_cyc();
      lsu_valid = 0;
      mid();
      chk("t6_pc", pcr_rx_bc_pc, 32'h0000_2000);
      chk("t6_mis_c1", misalign_err, 1);
      next_cyc();
      mid();
      chk("t6_mis_c2", misalign_err, 0);
      chk("t6_valid_c2", pcr_rx_valid, 1);
      #1;
      rstn = 0;
      #1;
      chk("t6_rst_valid", pcr_rx_valid, 0);
      chk("t6_rst_bc_valid", pcr_rx_bc_valid, 0);
      chk("t6_rst_pc", pcr_rx_bc_pc, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_cnt", grant_cnt, 0);
      chk("t6_rst_mis", misalign_err, 0);
      chk("t6_rst_ready", lsu_ready | exu_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
